// File: rtl/fir5_mac_unit.sv
// fir5_mac_unit: 5-tap unsigned FIR dot product, sum(data_i * coef_i).
// A single multiplier does the work over 5 accumulate cycles, under a
// start/busy/done handshake. A fill counter driven by shift_enable holds off
// computation until the shift register window holds 5 shifted-in samples.
// Optional macro FIR5_SAT_EN: saturate the result to all ones when the final
// sum does not fit in OUT_WIDTH bits. When it is undefined the result wraps.
module fir5_mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_shift_enable,
  input  logic                  i_flush,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  input  logic [DATA_WIDTH-1:0] i_data_2,
  input  logic [DATA_WIDTH-1:0] i_data_3,
  input  logic [DATA_WIDTH-1:0] i_data_4,
  input  logic [COEF_WIDTH-1:0] i_coef_0,
  input  logic [COEF_WIDTH-1:0] i_coef_1,
  input  logic [COEF_WIDTH-1:0] i_coef_2,
  input  logic [COEF_WIDTH-1:0] i_coef_3,
  input  logic [COEF_WIDTH-1:0] i_coef_4,
  output logic                  o_window_full,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [OUT_WIDTH-1:0]  o_result
);

  // Three guard bits are enough for 5 full-scale products.
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [2:0]            r_fill_cnt;
  logic [2:0]            w_fill_next;
  logic                  r_window_full;

  logic [ACC_WIDTH-1:0]  r_acc;
  logic [2:0]            r_idx;
  logic [OUT_WIDTH-1:0]  r_result;

  logic [DATA_WIDTH-1:0] w_tap_in  [5];
  logic [COEF_WIDTH-1:0] w_coef_in [5];
  logic [DATA_WIDTH-1:0] w_tap_q   [5];
  logic [COEF_WIDTH-1:0] w_coef_q  [5];

  logic [DATA_WIDTH-1:0] w_tap_sel;
  logic [COEF_WIDTH-1:0] w_coef_sel;
  logic [ACC_WIDTH-1:0]  w_prod;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic [OUT_WIDTH-1:0]  w_result_next;
  logic                  w_accept;
  logic                  w_last;

  assign w_tap_in[0]  = i_data_0;
  assign w_tap_in[1]  = i_data_1;
  assign w_tap_in[2]  = i_data_2;
  assign w_tap_in[3]  = i_data_3;
  assign w_tap_in[4]  = i_data_4;
  assign w_coef_in[0] = i_coef_0;
  assign w_coef_in[1] = i_coef_1;
  assign w_coef_in[2] = i_coef_2;
  assign w_coef_in[3] = i_coef_3;
  assign w_coef_in[4] = i_coef_4;

  // A start is only taken from IDLE with a full window; flush overrides it.
  assign w_accept = (r_state == ST_IDLE) && i_start && r_window_full && !i_flush;
  assign w_last   = (r_state == ST_ACC) && (r_idx == 3'd4);

  // Fill count: saturates at 5, cleared by flush (flush wins over shift).
  always_comb begin
    w_fill_next = r_fill_cnt;
    if (i_flush) begin
      w_fill_next = 3'd0;
    end else if (i_shift_enable && (r_fill_cnt < 3'd5)) begin
      w_fill_next = r_fill_cnt + 3'd1;
    end
  end

  // Fill counter and registered window_full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill_cnt    <= 3'd0;
      r_window_full <= 1'b0;
    end else begin
      r_fill_cnt    <= w_fill_next;
      r_window_full <= (w_fill_next == 3'd5);
    end
  end

  // Snapshot taps and coefficients at accept so later shifts cannot disturb
  // the computation in flight.
  for (genvar gi = 0; gi < 5; gi++) begin : gen_capture
    logic [DATA_WIDTH-1:0] r_tap;
    logic [COEF_WIDTH-1:0] r_coef;

    // Per-slot capture register, loaded only on the accepting edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_tap  <= '0;
        r_coef <= '0;
      end else if (w_accept) begin
        r_tap  <= w_tap_in[gi];
        r_coef <= w_coef_in[gi];
      end
    end

    assign w_tap_q[gi]  = r_tap;
    assign w_coef_q[gi] = r_coef;
  end

  // Select the operand pair for the current accumulate step.
  always_comb begin
    w_tap_sel  = '0;
    w_coef_sel = '0;
    for (int k = 0; k < 5; k++) begin
      if (r_idx == 3'(k)) begin
        w_tap_sel  = w_tap_q[k];
        w_coef_sel = w_coef_q[k];
      end
    end
  end

  assign w_prod = ACC_WIDTH'(w_tap_sel) * ACC_WIDTH'(w_coef_sel);
  assign w_sum  = r_acc + w_prod;

`ifdef FIR5_SAT_EN
  // Clamp to all ones when the sum exceeds the output range.
  assign w_result_next = (w_sum > ACC_WIDTH'({OUT_WIDTH{1'b1}})) ?
                         {OUT_WIDTH{1'b1}} : OUT_WIDTH'(w_sum);
`else
  // Keep the low OUT_WIDTH bits (modulo wrap).
  assign w_result_next = OUT_WIDTH'(w_sum);
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> ACC on accept, ACC -> DONE after step 4,
  // DONE -> IDLE after one cycle; flush always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_next = ST_ACC;
        ST_ACC:  if (w_last)   w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Accumulator, step index and result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_idx    <= 3'd0;
      r_result <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
      r_idx <= 3'd0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_idx <= 3'd0;
    end else if (r_state == ST_ACC) begin
      r_acc <= w_sum;
      r_idx <= r_idx + 3'd1;
      if (w_last) begin
        r_result <= w_result_next;
      end
    end
  end

  assign o_window_full = r_window_full;
  assign o_busy        = (r_state == ST_ACC);
  assign o_done        = (r_state == ST_DONE);
  assign o_result      = r_result;

endmodule
